// File: rtl/nios_mtl_sysinfo_pkg.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysinfo_pkg
//   Shared definitions for the system-information slave: the word-address map,
//   the layout version reported in the CAPS word, the value returned for
//   unmapped reads, the decoded register-select enum and small helper
//   functions for decode, CAPS assembly and byte-lane merging.
// -----------------------------------------------------------------------------
package nios_mtl_sysinfo_pkg;

  // Word-address map.
  localparam logic [31:0] ADDR_ID        = 32'd0;
  localparam logic [31:0] ADDR_TIMESTAMP = 32'd1;
  localparam logic [31:0] ADDR_CAPS      = 32'd2;
  localparam logic [31:0] ADDR_UPTIME_LO = 32'd3;
  localparam logic [31:0] ADDR_UPTIME_HI = 32'd4;
  localparam logic [31:0] ADDR_SCRATCH   = 32'd5;
  localparam logic [31:0] ADDR_USER0     = 32'd6;

  // Register-map layout version, top byte of the CAPS word.
  localparam logic [7:0]  SYSINFO_VERSION = 8'h02;

  // Value returned for any address outside the map.
  localparam logic [31:0] UNMAPPED_DATA = 32'h0000_0000;

  // Which register an address selects.
  typedef enum logic [2:0] {
    SEL_ID,
    SEL_TIMESTAMP,
    SEL_CAPS,
    SEL_UPTIME_LO,
    SEL_UPTIME_HI,
    SEL_SCRATCH,
    SEL_USER,
    SEL_NONE
  } reg_sel_e;

  // Map a zero-extended word address onto a register select.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input int unsigned num_user);
    reg_sel_e sel;
    if (addr == ADDR_ID)                sel = SEL_ID;
    else if (addr == ADDR_TIMESTAMP)    sel = SEL_TIMESTAMP;
    else if (addr == ADDR_CAPS)         sel = SEL_CAPS;
    else if (addr == ADDR_UPTIME_LO)    sel = SEL_UPTIME_LO;
    else if (addr == ADDR_UPTIME_HI)    sel = SEL_UPTIME_HI;
    else if (addr == ADDR_SCRATCH)      sel = SEL_SCRATCH;
    else if ((addr >= ADDR_USER0) && (addr < (ADDR_USER0 + num_user)))
                                        sel = SEL_USER;
    else                                sel = SEL_NONE;
    return sel;
  endfunction

  // CAPS = {version, NUM_USER, READ_LATENCY, ADDR_W}, one byte each.
  function automatic logic [31:0] caps_word(input int unsigned num_user,
                                            input int unsigned read_latency,
                                            input int unsigned addr_w);
    return {SYSINFO_VERSION, 8'(num_user), 8'(read_latency), 8'(addr_w)};
  endfunction

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/nios_mtl_sysinfo_if.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysinfo_if
//   Avalon-MM slave bus of the system-information block (no waitrequest).
//   master : drives address/read/write/writedata/byteenable,
//            receives readdata/readdatavalid.
//   slave  : the opposite direction.
// -----------------------------------------------------------------------------
interface nios_mtl_sysinfo_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/nios_mtl_sysinfo_rdpipe.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysinfo_rdpipe
//   Fixed-latency read-return pipeline: LATENCY stages of valid/data. A word
//   presented with valid_i at edge N leaves on valid_o/data_o in the cycle
//   after edge N+LATENCY-1. Each data stage only loads when the word entering
//   it is valid, so data_o holds the last returned word between pulses.
//   Asynchronous clear discards everything in flight.
//
//   clock, reset_n   : clock, asynchronous active-low clear
//   valid_i, data_i  : read accepted this cycle and its sampled data
//   valid_o, data_o  : one-cycle return pulse and held return data
// -----------------------------------------------------------------------------
module nios_mtl_sysinfo_rdpipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  // NOTE: the data stages are reset as well as the valid bits; the stage array
  // is tiny and the visible readdata must read back as zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/nios_mtl_sysinfo_qsys.sv
// -----------------------------------------------------------------------------
// nios_mtl_sysinfo_qsys
//   System-information Avalon-MM slave. Serves SYSTEM_ID, TIMESTAMP, a CAPS
//   word, a free-running 64-bit uptime counter (LO read snapshots HI), a
//   byte-writable SCRATCH register and NUM_USER constant user words. Reads are
//   accepted every cycle and returned after READ_LATENCY cycles with a
//   readdatavalid pulse.
//
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of nios_mtl_sysinfo_if (address, read, write,
//              writedata, byteenable in; readdata, readdatavalid out)
// -----------------------------------------------------------------------------
module nios_mtl_sysinfo_qsys
  import nios_mtl_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1459350768,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned NUM_USER     = 4,
  // Word k occupies bits [32k+31:32k]; kept at least one word wide so the
  // vector stays legal when NUM_USER is 0.
  parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_WORDS = '0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  nios_mtl_sysinfo_if.slave bus
);

  localparam logic [31:0] CAPS_VALUE = caps_word(NUM_USER, READ_LATENCY, ADDR_W);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] word_addr;
  reg_sel_e    sel;
  logic [31:0] user_word;
  logic [31:0] rd_data;

  assign word_addr = 32'(bus.address);
  assign sel       = decode_addr(word_addr, NUM_USER);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    user_word = UNMAPPED_DATA;
    for (int k = 0; k < NUM_USER; k++) begin
      if (word_addr == (ADDR_USER0 + 32'(k))) user_word = USER_WORDS[k*32 +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // State: uptime counter, HI snapshot, scratch
  // ---------------------------------------------------------------------------
  logic [63:0] uptime_q,   uptime_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic [31:0] scratch_q,  scratch_d;

  // Read data is sampled from the current (pre-edge) register values, so a
  // read accepted together with a SCRATCH write returns the old value and the
  // LO read and snapshot load see the same counter value.
  always_comb begin
    rd_data = UNMAPPED_DATA;
    case (sel)
      SEL_ID:        rd_data = SYSTEM_ID;
      SEL_TIMESTAMP: rd_data = TIMESTAMP;
      SEL_CAPS:      rd_data = CAPS_VALUE;
      SEL_UPTIME_LO: rd_data = uptime_q[31:0];
      SEL_UPTIME_HI: rd_data = snapshot_q;
      SEL_SCRATCH:   rd_data = scratch_q;
      SEL_USER:      rd_data = user_word;
      default:       rd_data = UNMAPPED_DATA;
    endcase
  end

  always_comb begin
    uptime_d   = uptime_q + 64'd1;  // wraps silently at 2^64-1
    snapshot_d = snapshot_q;
    scratch_d  = scratch_q;
    if (bus.read && (sel == SEL_UPTIME_LO)) snapshot_d = uptime_q[63:32];
    // A read in the same cycle takes priority and the write is dropped.
    if (bus.write && !bus.read && (sel == SEL_SCRATCH)) begin
      scratch_d = merge_bytes(scratch_q, bus.writedata, bus.byteenable);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q   <= '0;
      snapshot_q <= '0;
      scratch_q  <= '0;
    end else begin
      uptime_q   <= uptime_d;
      snapshot_q <= snapshot_d;
      scratch_q  <= scratch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline
  // ---------------------------------------------------------------------------
  logic        pipe_valid;
  logic [31:0] pipe_data;

  nios_mtl_sysinfo_rdpipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (32)
  ) u_rdpipe (
    .clock   (clock),
    .reset_n (reset_n),
    .valid_i (bus.read),
    .data_i  (rd_data),
    .valid_o (pipe_valid),
    .data_o  (pipe_data)
  );

  assign bus.readdatavalid = pipe_valid;
  assign bus.readdata      = pipe_data;

endmodule
